// File: rtl/mips_pkg.sv
// Shared encodings and constants for the MIPS pipeline control slice.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } ctrl_state_e;

   localparam logic [5:0] HALT_OPCODE = 6'b111111;
   localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use / branch-redirect detection for the ID stage, gated by an enable.
module hazard_detect
   import mips_pkg::*;
(
   input  logic       en_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_uses_rt_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rt_i,
   input  logic       branch_taken_i,
   output logic       load_use_o,
   output logic       stall_o,
   output logic       flush_o,
   output logic       bubble_o,
   output logic       pc_write_o
);

   logic lu;

   assign lu = ex_mem_read_i & (ex_rt_i != REG_ZERO) &
               ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
   assign load_use_o = lu;

   always_comb begin
      stall_o    = 1'b0;
      flush_o    = 1'b0;
      bubble_o   = 1'b0;
      pc_write_o = en_i;
      // A stall holds the branch in ID, so it is simply re-evaluated next cycle.
      if (en_i && lu) begin
         stall_o    = 1'b1;
         bubble_o   = 1'b1;
         pc_write_o = 1'b0;
      end else if (en_i && branch_taken_i) begin
         flush_o = 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencer: debug run/step/halt FSM with drain-on-HALT and hazard controls.
// Define PIPELINE_CTRL_PERF_EN to add the stall_count / flush_count outputs.
module pipeline_ctrl_unit #(
   parameter logic [5:0] HALT_OPCODE  = mips_pkg::HALT_OPCODE,
   parameter int         DRAIN_CYCLES = 3,
   parameter int         CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dbg_run,
   input  logic             dbg_step,
   input  logic             dbg_halt,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             id_branch_taken,
   output logic             clk_en,
   output logic             pc_write,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             halted,
   output logic [2:0]       ctrl_state,
   output logic [CNT_W-1:0] cycle_count
`ifdef PIPELINE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
`endif
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   mips_pkg::ctrl_state_e state_q, state_d;
   logic [DW-1:0]         drain_q, drain_d;
   logic [CNT_W-1:0]      cyc_q;
   logic                  hz_en, in_drain, halt_det;
   logic                  load_use, hz_stall, hz_flush, hz_bubble, hz_pcw;

   assign hz_en    = (state_q == mips_pkg::ST_RUN) || (state_q == mips_pkg::ST_STEP);
   assign in_drain = (state_q == mips_pkg::ST_DRAIN);
   assign clk_en   = hz_en | in_drain;
   assign halt_det = hz_en & (id_opcode == HALT_OPCODE) & ~load_use;

   // Hazard logic only sees RUN/STEP; DRAIN forces its own flush pattern.
   hazard_detect u_hazard (
      .en_i           (hz_en),
      .id_rs_i        (id_rs),
      .id_rt_i        (id_rt),
      .id_uses_rt_i   (id_uses_rt),
      .ex_mem_read_i  (ex_mem_read),
      .ex_rt_i        (ex_rt),
      .branch_taken_i (id_branch_taken),
      .load_use_o     (load_use),
      .stall_o        (hz_stall),
      .flush_o        (hz_flush),
      .bubble_o       (hz_bubble),
      .pc_write_o     (hz_pcw)
   );

   assign pc_write     = hz_pcw;
   assign if_id_stall  = hz_stall;
   assign if_id_flush  = hz_flush | in_drain;
   assign id_ex_bubble = hz_bubble;
   assign halted       = (state_q == mips_pkg::ST_HALTED);
   assign ctrl_state   = state_q;
   assign cycle_count  = cyc_q;

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      unique case (state_q)
         mips_pkg::ST_IDLE: begin
            if (dbg_halt)      state_d = mips_pkg::ST_IDLE;
            else if (dbg_run)  state_d = mips_pkg::ST_RUN;
            else if (dbg_step) state_d = mips_pkg::ST_STEP;
         end
         mips_pkg::ST_RUN: begin
            if (halt_det) begin
               state_d = mips_pkg::ST_DRAIN;
               drain_d = DW'(DRAIN_CYCLES - 1);
            end else if (dbg_halt) begin
               state_d = mips_pkg::ST_IDLE;
            end
         end
         mips_pkg::ST_STEP: begin
            if (halt_det) begin
               state_d = mips_pkg::ST_DRAIN;
               drain_d = DW'(DRAIN_CYCLES - 1);
            end else begin
               state_d = mips_pkg::ST_IDLE;
            end
         end
         mips_pkg::ST_DRAIN: begin
            if (drain_q == '0) state_d = mips_pkg::ST_HALTED;
            else               drain_d = drain_q - 1'b1;
         end
         mips_pkg::ST_HALTED: state_d = mips_pkg::ST_HALTED;
         default:             state_d = mips_pkg::ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= mips_pkg::ST_IDLE;
         drain_q <= '0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         if (clk_en) cyc_q <= cyc_q + 1'b1;
      end
   end

`ifdef PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // hz_flush excludes DRAIN flushes; both strobes are already clk_en-gated.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (hz_stall) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (hz_flush) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule
